// File: rtl/uart_ctrl.sv
// ---------------------------------------------------------------------------
// uart_ctrl
//
// CPU-side buffering for a byte UART.
//   * Transmit FIFO (TX_DEPTH entries): the CPU writes bytes, the UART
//     interface pops them one at a time with r_en.  The head byte is
//     presented combinationally on txd_from_fifo.
//   * Receive path: a small FSM watches the UART receive-complete flag,
//     captures the received byte into a receive buffer (RX_DEPTH entries),
//     then pulls uart_rxd_int_in low so the UART drops its flag.
//   * Sticky flags: ti (transmit drained), ri (byte received) and
//     ovr (byte lost because the receive buffer was full).
//
// Ports
//   clk_uart, rst_n         : clock, asynchronous active-low reset
//   tx_wr, tx_data, tx_full : CPU transmit write side
//   rx_rd, rx_data, rx_valid: CPU receive read side
//   ti/ti_clr, ri/ri_clr    : sticky interrupt flags and their clears
//   ovr                     : receive overrun flag (cleared by ri_clr)
//   txd_from_fifo, fifo_empty, r_en : UART transmit interface
//   uart_rxd_int, uart_r_data, uart_rxd_int_in : UART receive interface
// ---------------------------------------------------------------------------
module uart_ctrl #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 2
) (
   input  logic       clk_uart,
   input  logic       rst_n,
   // CPU transmit side
   input  logic       tx_wr,
   input  logic [7:0] tx_data,
   output logic       tx_full,
   // CPU receive side
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   // flags
   output logic       ti,
   input  logic       ti_clr,
   output logic       ri,
   input  logic       ri_clr,
   output logic       ovr,
   // UART interface
   output logic [7:0] txd_from_fifo,
   output logic       fifo_empty,
   input  logic       r_en,
   input  logic       uart_rxd_int,
   input  logic [7:0] uart_r_data,
   output logic       uart_rxd_int_in
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_AW + 1;

   localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
   localparam logic [TX_CW-1:0] TX_ONE_CNT  = TX_CW'(1);
   localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

   // ------------------------------------------------------------------
   // Transmit FIFO
   // ------------------------------------------------------------------
   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
   logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
   logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
   logic             ti_q, ti_d;
   logic             tx_push, tx_pop;

   assign tx_full       = (tx_cnt_q == TX_FULL_CNT);
   assign fifo_empty    = (tx_cnt_q == '0);
   assign tx_push       = tx_wr && !tx_full;
   assign tx_pop        = r_en && !fifo_empty;
   assign txd_from_fifo = tx_mem_q[tx_rd_ptr_q];
   assign ti            = ti_q;

   always_comb begin
      tx_wr_ptr_d = tx_wr_ptr_q;
      tx_rd_ptr_d = tx_rd_ptr_q;
      tx_cnt_d    = tx_cnt_q;
      ti_d        = ti_q;

      // Pointers wrap naturally because the depth is a power of two.
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;

      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase

      // Draining the last byte sets ti; the set beats a coincident clear.
      if (ti_clr) ti_d = 1'b0;
      if (tx_pop && !tx_push && (tx_cnt_q == TX_ONE_CNT)) ti_d = 1'b1;
   end

   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_cnt_q    <= '0;
         ti_q        <= 1'b0;
      end else begin
         if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_data;
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_cnt_q    <= tx_cnt_d;
         ti_q        <= ti_d;
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE    = 2'd0,
      RX_CAPTURE = 2'd1,
      RX_CLEAR   = 2'd2,
      RX_WAIT    = 2'd3
   } rx_state_t;

   rx_state_t rx_state_q, rx_state_d;
   logic      rx_int_in_q;

   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:    if (uart_rxd_int) rx_state_d = RX_CAPTURE;
         RX_CAPTURE: rx_state_d = RX_CLEAR;
         RX_CLEAR:   rx_state_d = RX_WAIT;
         RX_WAIT:    if (!uart_rxd_int) rx_state_d = RX_IDLE;
         default:    rx_state_d = RX_IDLE;
      endcase
   end

   // The feedback is registered from the next state so it lines up with
   // the state it describes: high while idle/capturing, low while the
   // UART is being told to drop its receive flag.
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q  <= RX_IDLE;
         rx_int_in_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_int_in_q <= (rx_state_d == RX_IDLE) || (rx_state_d == RX_CAPTURE);
      end
   end

   assign uart_rxd_int_in = rx_int_in_q;

   // ------------------------------------------------------------------
   // Receive buffer and flags
   // ------------------------------------------------------------------
   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
   logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
   logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
   logic             ri_q, ri_d;
   logic             ovr_q, ovr_d;
   logic             rx_capture, rx_push, rx_pop, rx_drop, rx_full;

   assign rx_valid   = (rx_cnt_q != '0);
   assign rx_full    = (rx_cnt_q == RX_FULL_CNT);
   assign rx_pop     = rx_rd && rx_valid;
   assign rx_capture = (rx_state_q == RX_CAPTURE);
   // A same-cycle CPU pop frees a slot, so a full buffer still accepts.
   assign rx_push    = rx_capture && (!rx_full || rx_pop);
   assign rx_drop    = rx_capture && !rx_push;
   assign rx_data    = rx_mem_q[rx_rd_ptr_q];
   assign ri         = ri_q;
   assign ovr        = ovr_q;

   always_comb begin
      rx_wr_ptr_d = rx_wr_ptr_q;
      rx_rd_ptr_d = rx_rd_ptr_q;
      rx_cnt_d    = rx_cnt_q;
      ri_d        = ri_q;
      ovr_d       = ovr_q;

      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;

      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase

      if (ri_clr) begin
         ri_d  = 1'b0;
         ovr_d = 1'b0;
      end
      if (rx_capture) ri_d  = 1'b1;
      if (rx_drop)    ovr_d = 1'b1;
   end

   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         ri_q        <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         if (rx_push) rx_mem_q[rx_wr_ptr_q] <= uart_r_data;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         ri_q        <= ri_d;
         ovr_q       <= ovr_d;
      end
   end

endmodule
